// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header byte N, then N big-endian 32-bit words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_dbg
);

    // A byte moves only when byte_valid && byte_ready in the same cycle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        DONE  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd5,
`endif
        ERR   = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_sr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic take;
    logic last_word;
    logic hdr_bad;

    assign take      = byte_valid && byte_ready;
    assign last_word = (32'(word_idx) == (32'(n_words) - 32'd1));
    assign hdr_bad   = (byte_in == 8'd0) || (32'(byte_in) > MAX_WORDS);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_words    <= 8'd0;
            word_idx   <= '0;
            byte_cnt   <= 2'd0;
            word_sr    <= 24'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= HDR;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_idx   <= '0;
                        byte_cnt   <= 2'd0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                HDR: begin
                    if (take) begin
                        n_words <= byte_in;
                        if (hdr_bad) begin
                            state      <= ERR;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (take) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {word_sr[15:0], byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_in;
`endif
                        if (byte_cnt == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_addr <= word_idx;
                            wr_data <= {word_sr, byte_in};
                            // Last word: stop accepting; the index is left in place so it never wraps.
                            if (last_word) begin
                                byte_ready <= 1'b0;
                            end else begin
                                word_idx <= word_idx + ADDR_W'(1);
                            end
                        end
                    end else if (!byte_ready) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= CHECK;
                        byte_ready <= 1'b1;
`else
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (take) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, the instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 64, the largest legal image size in words (2**ADDR_W).
REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have start  input  1  a one-cycle pulse that arms a load.
REQ-006 SHALL have byte_in  input  8  the incoming image byte.
REQ-007 SHALL have byte_valid  input  1  qualifying byte_in.
REQ-008 SHALL have byte_ready  output  1  set when the loader accepts a byte this cycle.
REQ-009 SHALL have wr_en  output  1  the instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have wr_addr  output  ADDR_W  the word address being written.
REQ-011 SHALL have wr_data  output  32  the assembled instruction word.
REQ-012 SHALL have busy  output  1  high while loading; holds the CPU (PC and fetch) off.
REQ-013 SHALL have done  output  1  a level meaning the image loaded successfully.
REQ-014 SHALL have error  output  1  a level meaning the load was aborted.

Function
REQ-015 SHALL implement states IDLE, HDR, LOAD, CHECK, DONE and ERR.
REQ-016 SHALL transfer a byte only on a cycle where byte_valid and byte_ready are both 1; all other cycles consume nothing.
REQ-017 SHALL drive byte_ready = 1 only in HDR, LOAD and CHECK.
REQ-018 SHALL move from IDLE, DONE or ERR to HDR on start; start SHALL be ignored in HDR, LOAD and CHECK.
REQ-019 SHALL, on entry to HDR, clear done, error, the word index, the byte counter and the checksum.
REQ-020 SHALL treat the HDR byte as word count N: N in 1..MAX_WORDS goes to LOAD; N = 0 or N > MAX_WORDS goes to ERR.
REQ-021 SHALL, in LOAD, shift bytes into a 32-bit word MSB-first (first byte goes to bits 31:24).
REQ-022 SHALL, on the 4th accepted byte of a word, assert wr_en for exactly the next cycle, with wr_addr = word index (starting at 0) and wr_data = the assembled word.
REQ-023 SHALL increment the word index after each write; after word N-1 it SHALL leave LOAD and never wrap the address.
REQ-024 SHALL hold wr_addr and wr_data stable whenever wr_en = 0.
REQ-025 SHALL keep busy = 1 in HDR, LOAD and CHECK, and 0 otherwise.
REQ-026 SHALL hold done and error as levels until the next start or rst; done and error SHALL never both be 1.
REQ-027 SHALL handle byte_valid gaps of any length without changing the result.

Reset
REQ-028 SHALL, on rst (including mid-load), go to IDLE with byte_ready = wr_en = busy = done = error = 0, wr_addr = 0, wr_data = 0, and clear the counters and checksum.
REQ-029 SHALL leave words already written by a reset-interrupted load untouched; no rollback.

Configuration
REQ-030 SHALL compile an XOR checksum check in when IMEM_LOADER_CHECKSUM_EN is defined.
REQ-031 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, XOR every LOAD-state byte (the header byte is excluded), go from LOAD to CHECK after the last write, and accept one byte there: a match goes to DONE, a mismatch goes to ERR.
REQ-032 SHALL, without IMEM_LOADER_CHECKSUM_EN, go from LOAD directly to DONE in the cycle after the last wr_en; the CHECK state and checksum register SHALL be absent.

Verification
REQ-033 SHALL be verified with: rst, start, then bytes 02 00 08 40 20 00 09 48 20 (plus 09 when the checksum is enabled) -> wr_en at addr 0 with 0x00084020, wr_en at addr 1 with 0x00094820, done = 1, busy = 0.
REQ-034 SHALL be verified with: start, header 00 or 41 -> error = 1, done = 0, no wr_en, byte_ready = 0.
REQ-035 SHALL be verified with: header 40 followed by 256 bytes -> 64 writes, last at addr 63, no write at addr 0 after the first, done = 1.
REQ-036 SHALL be verified with: the REQ-033 stream with random 0-5 cycle byte_valid gaps -> identical wr_en/addr/data sequence.
REQ-037 SHALL be verified with: the checksum enabled and the REQ-033 stream ending in 0A -> both writes occur, error = 1, done = 0.
REQ-038 SHALL be verified with: rst asserted after 5 LOAD bytes -> next cycle in IDLE, all outputs 0; a subsequent start and full stream loads correctly from addr 0.
